// File: rtl/gpgpu_kernel_launcher.sv
// ============================================================================
// gpgpu_kernel_launcher
// ----------------------------------------------------------------------------
// Host-side kernel launcher that sits directly upstream of the GPGPU host port.
// It accepts one kernel descriptor, expands it into num_wg sequential workgroup
// requests with ids wg_base, wg_base+1, ... (mod 2^WGID_W), collects the
// workgroup-done responses, and pulses done_o once every issued workgroup has
// retired. At most MAX_INFLIGHT workgroups may be issued but not yet retired.
//
// Optional feature macro: LAUNCHER_PERF_EN
//   defined   -> 32-bit saturating kernel cycle counter on perf_cycles_o
//   undefined -> perf_cycles_o tied to 0
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   launch_valid_i     kernel launch request
//   launch_ready_o     launcher idle and able to accept a kernel
//   launch_num_wg_i    workgroup count (0 allowed, up to 2^WGID_W)
//   launch_wg_base_i   id of the first workgroup
//   launch_desc_i      packed descriptor, latched on accept
//   host_req_valid_o   workgroup request valid
//   host_req_ready_i   GPU accepts the workgroup
//   host_req_wg_id_o   wg_base + issue index (mod 2^WGID_W)
//   host_req_desc_o    latched descriptor, constant for the whole kernel
//   host_rsp_valid_i   workgroup done
//   host_rsp_ready_o   launcher accepts the done response
//   host_rsp_wg_id_i   id of the finished workgroup
//   done_o             one-cycle pulse when the kernel completes
//   err_o              sticky flag: unexpected or out-of-range response
//   perf_cycles_o      cycles spent in ISSUE+DRAIN for the last kernel
// ============================================================================
module gpgpu_kernel_launcher #(
    parameter int WGID_W       = 8,
    parameter int DESC_W       = 256,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              launch_valid_i,
    output logic              launch_ready_o,
    input  logic [WGID_W:0]   launch_num_wg_i,
    input  logic [WGID_W-1:0] launch_wg_base_i,
    input  logic [DESC_W-1:0] launch_desc_i,
    output logic              host_req_valid_o,
    input  logic              host_req_ready_i,
    output logic [WGID_W-1:0] host_req_wg_id_o,
    output logic [DESC_W-1:0] host_req_desc_o,
    input  logic              host_rsp_valid_i,
    output logic              host_rsp_ready_o,
    input  logic [WGID_W-1:0] host_rsp_wg_id_i,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       perf_cycles_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counters are one bit wider than the id so a full 2^WGID_W kernel fits.
    localparam logic [WGID_W:0] CNT_ONE        = (WGID_W+1)'(1);
    localparam logic [WGID_W:0] INFLIGHT_LIMIT = (WGID_W+1)'(MAX_INFLIGHT);

    state_t              state;
    state_t              state_nx;
    logic [WGID_W:0]     num_wg;
    logic [WGID_W-1:0]   wg_base;
    logic [DESC_W-1:0]   desc;
    logic [WGID_W:0]     issued;
    logic [WGID_W:0]     retired;
    logic [WGID_W:0]     issued_nx;
    logic [WGID_W:0]     retired_nx;
    logic [WGID_W:0]     inflight_nx;
    logic [WGID_W-1:0]   rsp_offset;
    logic                rsp_bad;
    logic                launch_fire;
    logic                req_fire;
    logic                rsp_fire;
    logic                req_valid_q;
    logic                launch_ready_q;
    logic                rsp_ready_q;
    logic                done_q;
    logic                err_q;

    assign launch_fire = launch_valid_i & launch_ready_q;
    assign req_fire    = req_valid_q & host_req_ready_i;
    assign rsp_fire    = host_rsp_valid_i & rsp_ready_q;

    // Response check: the id must fall inside [wg_base, wg_base+issued) taken
    // modulo 2^WGID_W, and a response with nothing outstanding is always bad.
    assign rsp_offset  = host_rsp_wg_id_i - wg_base;
    assign rsp_bad     = ({1'b0, rsp_offset} >= issued) || (retired == issued);

    // Next-state and next-counter values. The registered handshake outputs are
    // derived from these so that a fire in this cycle is already reflected in
    // the valid/ready presented next cycle.
    always_comb begin
        state_nx   = state;
        issued_nx  = issued + (req_fire ? CNT_ONE : '0);
        retired_nx = retired + (rsp_fire ? CNT_ONE : '0);
        case (state)
            IDLE: begin
                if (launch_fire) begin
                    issued_nx  = '0;
                    retired_nx = '0;
                    state_nx   = (launch_num_wg_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (req_fire && (issued == num_wg - CNT_ONE)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (retired_nx >= num_wg) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Same-cycle issue and retire cancel out in the inflight count.
    assign inflight_nx = issued_nx - retired_nx;

    // Main FSM register plus all registered outputs and the latched kernel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            num_wg         <= '0;
            wg_base        <= '0;
            desc           <= '0;
            issued         <= '0;
            retired        <= '0;
            req_valid_q    <= 1'b0;
            launch_ready_q <= 1'b1;
            rsp_ready_q    <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state   <= state_nx;
            issued  <= issued_nx;
            retired <= retired_nx;
            if (launch_fire) begin
                num_wg  <= launch_num_wg_i;
                wg_base <= launch_wg_base_i;
                desc    <= launch_desc_i;
            end
            req_valid_q    <= (state_nx == ISSUE) && (inflight_nx < INFLIGHT_LIMIT);
            launch_ready_q <= (state_nx == IDLE);
            rsp_ready_q    <= (state_nx == ISSUE) || (state_nx == DRAIN);
            done_q         <= (state_nx == DONE);
            if (rsp_fire && rsp_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign launch_ready_o   = launch_ready_q;
    assign host_req_valid_o = req_valid_q;
    assign host_req_wg_id_o = wg_base + issued[WGID_W-1:0];
    assign host_req_desc_o  = desc;
    assign host_rsp_ready_o = rsp_ready_q;
    assign done_o           = done_q;
    assign err_o            = err_q;

`ifdef LAUNCHER_PERF_EN
    logic [31:0] perf_cnt;

    // Kernel cycle counter: restarts on launch, counts ISSUE+DRAIN cycles,
    // saturates, and naturally holds its final value through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (launch_fire) begin
            perf_cnt <= '0;
        end else if (((state == ISSUE) || (state == DRAIN)) && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_cycles_o = perf_cnt;
`else
    assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_gpgpu_kernel_launcher.sv
// ============================================================================
// tb_gpgpu_kernel_launcher
// ----------------------------------------------------------------------------
// Scoreboard bench for gpgpu_kernel_launcher. The main process launches
// kernels and pushes the expected workgroup ids and completion records; a
// driver process plays the GPU side (random req_ready, delayed responses);
// a monitor process keeps an abstract kernel model (issued/retired counts,
// id window, sticky error) and checks every DUT output on the falling edge.
// ============================================================================
module tb_gpgpu_kernel_launcher;

    localparam int WGID_W       = 8;
    localparam int DESC_W       = 256;
    localparam int MAX_INFLIGHT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              launch_valid_i;
    logic              launch_ready_o;
    logic [WGID_W:0]   launch_num_wg_i;
    logic [WGID_W-1:0] launch_wg_base_i;
    logic [DESC_W-1:0] launch_desc_i;
    logic              host_req_valid_o;
    logic              host_req_ready_i;
    logic [WGID_W-1:0] host_req_wg_id_o;
    logic [DESC_W-1:0] host_req_desc_o;
    logic              host_rsp_valid_i;
    logic              host_rsp_ready_o;
    logic [WGID_W-1:0] host_rsp_wg_id_i;
    logic              done_o;
    logic              err_o;
    logic [31:0]       perf_cycles_o;

    gpgpu_kernel_launcher #(
        .WGID_W       (WGID_W),
        .DESC_W       (DESC_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .launch_valid_i   (launch_valid_i),
        .launch_ready_o   (launch_ready_o),
        .launch_num_wg_i  (launch_num_wg_i),
        .launch_wg_base_i (launch_wg_base_i),
        .launch_desc_i    (launch_desc_i),
        .host_req_valid_o (host_req_valid_o),
        .host_req_ready_i (host_req_ready_i),
        .host_req_wg_id_o (host_req_wg_id_o),
        .host_req_desc_o  (host_req_desc_o),
        .host_rsp_valid_i (host_rsp_valid_i),
        .host_rsp_ready_o (host_rsp_ready_o),
        .host_rsp_wg_id_i (host_rsp_wg_id_i),
        .done_o           (done_o),
        .err_o            (err_o),
        .perf_cycles_o    (perf_cycles_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WGID_W-1:0] id;
        int                due;
    } rsp_entry_t;

    // Scoreboard queues and GPU-side response bookkeeping.
    logic [WGID_W-1:0] exp_req_q[$];
    int                exp_done_q[$];
    rsp_entry_t        pending[$];
    logic [WGID_W-1:0] inject_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    bit rsp_hold        = 1'b0;
    bit ready_random    = 1'b0;
    int rsp_delay_fixed = -1;

    int cycle          = 0;
    int req_fire_total = 0;
    int rsp_fire_total = 0;

    // Abstract kernel model owned by the monitor.
    bit          k_active = 1'b0;
    int          k_n      = 0;
    int          k_base   = 0;
    int          k_issued = 0;
    int          k_retired = 0;
    logic [DESC_W-1:0] k_desc = '0;
    bit          fresh    = 1'b1;
    bit          exp_err  = 1'b0;
    logic [31:0] exp_perf = '0;

    task automatic checkOutput(input string name, input logic [DESC_W-1:0] act,
                               input logic [DESC_W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: checks every output against the model, then applies this
    // cycle's handshakes to the model so they show up from the next cycle.
    initial begin
        int phase;
        int off;
        int n_done;
        logic [WGID_W-1:0] rid;
        forever begin
            @(negedge clk);
            if (rst) begin
                k_active  = 1'b0;
                k_issued  = 0;
                k_retired = 0;
                fresh     = 1'b1;
                exp_err   = 1'b0;
                exp_perf  = '0;
                exp_req_q.delete();
                exp_done_q.delete();
                pending.delete();
                continue;
            end
            if (!k_active)                phase = 0;
            else if (k_issued < k_n)      phase = 1;
            else if (k_retired < k_n)     phase = 2;
            else                          phase = 3;

            checkOutput("launch_ready", launch_ready_o, phase == 0);
            checkOutput("req_valid", host_req_valid_o,
                        (phase == 1) && ((k_issued - k_retired) < MAX_INFLIGHT));
            checkOutput("rsp_ready", host_rsp_ready_o, (phase == 1) || (phase == 2));
            checkOutput("done", done_o, phase == 3);
            checkOutput("err", err_o, exp_err);
`ifdef LAUNCHER_PERF_EN
            checkOutput("perf_cycles", perf_cycles_o, exp_perf);
`else
            checkOutput("perf_cycles", perf_cycles_o, 0);
`endif
            if (fresh) begin
                checkOutput("reset_wg_id", host_req_wg_id_o, 0);
                checkOutput("reset_desc", host_req_desc_o, 0);
            end
            if (host_req_valid_o && exp_req_q.size() != 0) begin
                checkOutput("req_wg_id", host_req_wg_id_o, exp_req_q[0]);
                checkOutput("req_desc", host_req_desc_o, k_desc);
            end

            if (((phase == 1) || (phase == 2)) && (exp_perf != 32'hFFFF_FFFF))
                exp_perf = exp_perf + 32'd1;

            if (launch_valid_i && launch_ready_o) begin
                k_active  = 1'b1;
                k_n       = int'(launch_num_wg_i);
                k_base    = int'(launch_wg_base_i);
                k_desc    = launch_desc_i;
                k_issued  = 0;
                k_retired = 0;
                fresh     = 1'b0;
                exp_perf  = '0;
            end
            if (host_req_valid_o && host_req_ready_i) begin
                req_fire_total++;
                checkOutput("req_expected", exp_req_q.size() != 0, 1);
                if (exp_req_q.size() != 0) void'(exp_req_q.pop_front());
                pending.push_back('{id: host_req_wg_id_o,
                                    due: cycle + ((rsp_delay_fixed >= 0) ? rsp_delay_fixed
                                                                         : int'($urandom_range(0, 6)))});
                k_issued++;
            end
            if (host_rsp_valid_i && host_rsp_ready_o) begin
                rsp_fire_total++;
                rid = host_rsp_wg_id_i;
                off = (int'(rid) - k_base) & 255;
                if (off >= k_issued || k_retired == k_issued) exp_err = 1'b1;
                k_retired++;
                for (int i = 0; i < pending.size(); i++) begin
                    if (pending[i].id == rid) begin
                        pending.delete(i);
                        break;
                    end
                end
            end
            if (done_o) begin
                checkOutput("done_expected", exp_done_q.size() != 0, 1);
                if (exp_done_q.size() != 0) begin
                    n_done = exp_done_q.pop_front();
                    checkOutput("done_wg_count", k_issued, n_done);
                    checkOutput("done_reqs_left", exp_req_q.size(), 0);
                end
            end
            if (phase == 3) k_active = 1'b0;
        end
    end

    // GPU-side driver: random request backpressure, delayed responses
    // (possibly out of order), and directed response injection.
    initial begin
        bit                pres_active;
        int                pres_timer;
        logic [WGID_W-1:0] pres_id;
        int                seen_rsp;
        int                idx;
        pres_active = 1'b0;
        pres_timer  = 0;
        pres_id     = '0;
        seen_rsp    = 0;
        host_req_ready_i = 1'b0;
        host_rsp_valid_i = 1'b0;
        host_rsp_wg_id_i = '0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (pres_active && rsp_fire_total != seen_rsp) pres_active = 1'b0;
            seen_rsp = rsp_fire_total;
            if (rst) begin
                pres_active = 1'b0;
                inject_q.delete();
            end
            if (pres_active) begin
                pres_timer--;
                if (pres_timer <= 0) pres_active = 1'b0;
            end
            if (!pres_active) begin
                if (inject_q.size() != 0) begin
                    pres_id     = inject_q.pop_front();
                    pres_timer  = 3;
                    pres_active = 1'b1;
                end else if (!rsp_hold && pending.size() != 0) begin
                    idx = int'($urandom_range(0, pending.size() - 1));
                    if (pending[idx].due <= cycle) begin
                        pres_id = pending[idx].id;
                        pending.delete(idx);
                        pres_timer  = 200;
                        pres_active = 1'b1;
                    end
                end
            end
            host_rsp_valid_i = pres_active;
            host_rsp_wg_id_i = pres_id;
            host_req_ready_i = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic pulseReset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Launch one kernel and push its expected ids and completion record.
    task automatic applyStimulus(input int n, input int base, output int launch_cycle);
        logic [DESC_W-1:0] d;
        bit fired;
        for (int i = 0; i < DESC_W / 32; i++) d[i*32 +: 32] = $urandom();
        fired = 1'b0;
        launch_cycle = -1;
        @(posedge clk);
        #1;
        launch_valid_i   = 1'b1;
        launch_num_wg_i  = (WGID_W+1)'(n);
        launch_wg_base_i = WGID_W'(base);
        launch_desc_i    = d;
        for (int c = 0; c < 50 && !fired; c++) begin
            @(negedge clk);
            if (launch_ready_o) begin
                fired = 1'b1;
                launch_cycle = cycle;
                for (int i = 0; i < n; i++) exp_req_q.push_back(WGID_W'(base + i));
                exp_done_q.push_back(n);
            end
        end
        checkOutput("launch_accepted", fired, 1);
        @(posedge clk);
        #1 launch_valid_i = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int done_cycle);
        bit seen;
        seen = 1'b0;
        done_cycle = -1;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                done_cycle = cycle;
            end
        end
        checkOutput("done_within_budget", seen, 1);
        if (!seen) pulseReset();
    endtask

    task automatic waitFires(input int start, input int count);
        for (int c = 0; c < 100 && (req_fire_total - start) < count; c++) @(negedge clk);
    endtask

    initial begin
        int lc;
        int dc;
        int start;
        int rsp_before;
        int n;
        launch_valid_i   = 1'b0;
        launch_num_wg_i  = '0;
        launch_wg_base_i = '0;
        launch_desc_i    = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Four workgroups, always ready, responses two cycles later.
        rsp_delay_fixed = 2;
        applyStimulus(4, 8'h10, lc);
        waitDone(200, dc);
        checkOutput("t1_err", err_o, 0);

        // Empty kernel completes one cycle after launch.
        applyStimulus(0, $urandom_range(0, 255), lc);
        waitDone(20, dc);
        checkOutput("t2_done_latency", dc - lc, 1);

        // Inflight limit with responses withheld, then one release.
        rsp_hold = 1'b1;
        start = req_fire_total;
        n = int'($urandom_range(0, 255));
        applyStimulus(20, n, lc);
        repeat (40) @(negedge clk);
        checkOutput("t3_fires_at_limit", req_fire_total - start, 16);
        inject_q.push_back(WGID_W'(n));
        repeat (10) @(negedge clk);
        checkOutput("t3_fires_after_release", req_fire_total - start, 17);
        rsp_hold = 1'b0;
        rsp_delay_fixed = -1;
        waitDone(400, dc);

        // Id wrap across the top of the id space.
        applyStimulus(3, 8'hFE, lc);
        waitDone(200, dc);
        checkOutput("t4_err", err_o, 0);

        // Randomized kernels, including a full 256-workgroup one.
        ready_random = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n = (k == 5) ? 256 : int'($urandom_range(0, 40));
            applyStimulus(n, $urandom_range(0, 255), lc);
            waitDone(5000, dc);
            checkOutput("rand_err", err_o, 0);
        end
        ready_random = 1'b0;

        // Out-of-window response, then a response while idle.
        rsp_hold = 1'b1;
        start = req_fire_total;
        applyStimulus(2, 8'h20, lc);
        waitFires(start, 2);
        inject_q.push_back(8'h50);
        repeat (5) @(negedge clk);
        checkOutput("t5_err_set", err_o, 1);
        inject_q.push_back(8'h20);
        waitDone(50, dc);
        rsp_before = rsp_fire_total;
        inject_q.push_back(8'h21);
        repeat (6) @(negedge clk);
        checkOutput("t5_idle_rsp_ignored", rsp_fire_total - rsp_before, 0);
        checkOutput("t5_err_sticky", err_o, 1);

        // Reset in the middle of issuing abandons the kernel silently.
        start = req_fire_total;
        applyStimulus(10, $urandom_range(0, 255), lc);
        waitFires(start, 2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_launch_ready", launch_ready_o, 1);
        checkOutput("t6_req_valid", host_req_valid_o, 0);
        checkOutput("t6_err", err_o, 0);
        checkOutput("t6_wg_id", host_req_wg_id_o, 0);
        rsp_before = rsp_fire_total;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("t6_no_done", done_o, 0);
        end
        rsp_hold = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
